// File: rtl/countdown_timer_pkg.sv
// Shared constants for the M:SS countdown timer blocks.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  function automatic logic is_valid_bcd(input logic [3:0] digit);
    return digit <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit register: parallel load, decrement with wrap, borrow-out when decrementing from 0.
module bcd_down_digit
  import countdown_timer_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_MAX
) (
  input  logic       clock,
  input  logic       clear_,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] value,
  output logic       borrow
);

  assign borrow = dec & (value == 4'd0);

  always_ff @(posedge clock or negedge clear_) begin
    if (!clear_) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_val;
    end else if (dec) begin
      value <= (value == 4'd0) ? WRAP : value - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Three-digit BCD countdown timer (M:SS): shift-in digit entry while idle, 1 Hz countdown in run.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic       clock,
  input  logic       clear_,
  input  logic [3:0] bcd_in,
  input  logic       load_,
  input  logic       enable_,
  output logic [3:0] mins,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       running,
  output logic       done
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LastTick = PW'(TICKS_PER_SEC - 1);

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic          load_q;
  logic          running_q;
  logic          done_q;

  logic load_edge;
  logic shift;
  logic tick;
  logic last_sec;
  logic ones_borrow;
  logic tens_borrow;
  logic unused_mins_borrow;

  assign load_edge = load_q & ~load_;
  assign shift     = (state_q == StIdle) & load_edge & is_valid_bcd(bcd_in);
  // A decrement due on the pausing edge is dropped, hence the enable_ term.
  assign tick      = (state_q == StRun) & ~enable_ & (presc_q == LastTick);
  assign zero      = (mins == 4'd0) & (sec_tens == 4'd0) & (sec_ones == 4'd0);
  assign last_sec  = (mins == 4'd0) & (sec_tens == 4'd0) & (sec_ones == 4'd1);
  assign running   = running_q;
  assign done      = done_q;

  bcd_down_digit #(.WRAP(BCD_MAX)) u_sec_ones (
    .clock    (clock),
    .clear_   (clear_),
    .load     (shift),
    .load_val (bcd_in),
    .dec      (tick),
    .value    (sec_ones),
    .borrow   (ones_borrow)
  );

  bcd_down_digit #(.WRAP(SEC_TENS_MAX)) u_sec_tens (
    .clock    (clock),
    .clear_   (clear_),
    .load     (shift),
    .load_val (sec_ones),
    .dec      (ones_borrow),
    .value    (sec_tens),
    .borrow   (tens_borrow)
  );

  bcd_down_digit #(.WRAP(BCD_MAX)) u_mins (
    .clock    (clock),
    .clear_   (clear_),
    .load     (shift),
    .load_val (sec_tens),
    .dec      (tens_borrow),
    .value    (mins),
    .borrow   (unused_mins_borrow)
  );

  always_ff @(posedge clock or negedge clear_) begin
    if (!clear_) begin
      state_q   <= StIdle;
      presc_q   <= '0;
      load_q    <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      load_q <= load_;
      unique case (state_q)
        StIdle: begin
          // Uses pre-shift zero so a same-cycle load cannot start a 0:00 timer.
          if (!enable_ && !zero) begin
            state_q   <= StRun;
            presc_q   <= '0;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (enable_) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            running_q <= 1'b0;
          end else if (presc_q == LastTick) begin
            presc_q <= '0;
            if (last_sec) begin
              state_q   <= StDone;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        StDone: begin
          if (enable_) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          presc_q   <= '0;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: vector table, directed multi-cycle sequences, random vs. model.
module tb_countdown_timer;

  localparam int T = 4;

  logic       clock = 1'b0;
  logic       clear_ = 1'b0;
  logic [3:0] bcd_in = 4'd0;
  logic       load_ = 1'b1;
  logic       enable_ = 1'b1;
  logic [3:0] mins, sec_tens, sec_ones;
  logic       zero, running, done;

  int checks = 0;
  int failures = 0;

  countdown_timer #(.TICKS_PER_SEC(T)) dut (
    .clock    (clock),
    .clear_   (clear_),
    .bcd_in   (bcd_in),
    .load_    (load_),
    .enable_  (enable_),
    .mins     (mins),
    .sec_tens (sec_tens),
    .sec_ones (sec_ones),
    .zero     (zero),
    .running  (running),
    .done     (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       clr_n;
    logic       ld;
    logic [3:0] bcd;
    logic       en;
    logic [3:0] m, t, o;
    logic       z, r, d;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, input logic l, input logic [3:0] b, input logic e,
                              input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                              input logic z, input logic r, input logic d);
    vec_t v;
    v.clr_n = c; v.ld = l; v.bcd = b; v.en = e;
    v.m = m; v.t = t; v.o = o; v.z = z; v.r = r; v.d = d;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] m, input logic [3:0] t,
                       input logic [3:0] o, input logic z, input logic r, input logic d);
    logic [14:0] got, exp;
    got = {mins, sec_tens, sec_ones, zero, running, done};
    exp = {m, t, o, z, r, d};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h:%h%h z=%b r=%b d=%b, expected %h:%h%h z=%b r=%b d=%b", name,
               mins, sec_tens, sec_ones, zero, running, done, m, t, o, z, r, d);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_digit(input logic [3:0] dg);
    load_ = 1'b0; bcd_in = dg; step();
    load_ = 1'b1; step();
  endtask

  task automatic load3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    load_digit(a); load_digit(b); load_digit(c);
  endtask

  task automatic do_clear();
    clear_ = 1'b0; #1; clear_ = 1'b1;
  endtask

  // Reference model: time held as the decimal number M*100 + T*10 + O.
  int n, mode, run_cnt;  // mode: 0 idle, 1 run, 2 done
  bit prev_ld;

  function automatic int dec_time(input int v);
    int r;
    r = v - 1;
    if (r % 100 == 99) r = r - 40;  // x:00 -> (x-1):59
    return r;
  endfunction

  task automatic model_reset();
    n = 0; mode = 0; run_cnt = 0; prev_ld = 1'b1;
  endtask

  task automatic model_clock();
    bit edge_seen, start;
    edge_seen = prev_ld && !load_;
    prev_ld = load_;
    case (mode)
      0: begin
        start = !enable_ && (n != 0);
        if (edge_seen && int'(bcd_in) <= 9) n = (n % 100) * 10 + int'(bcd_in);
        if (start) begin mode = 1; run_cnt = 0; end
      end
      1: begin
        if (enable_) mode = 0;
        else begin
          run_cnt++;
          if (run_cnt % T == 0) begin
            n = dec_time(n);
            if (n == 0) mode = 2;
          end
        end
      end
      default: if (enable_) mode = 0;
    endcase
  endtask

  task automatic check_model(input string name);
    check(name, 4'(n / 100), 4'((n / 10) % 10), 4'(n % 10), n == 0, mode == 1, mode == 2);
  endtask

  initial begin
    // Table: reset, load/hold, invalid digits, zero start, simultaneous load+start.
    add(0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 1, 1, 1, 0, 0, 1, 0, 0, 0);
    add(1, 0, 3, 1, 0, 1, 3, 0, 0, 0);
    add(1, 1, 3, 1, 0, 1, 3, 0, 0, 0);
    add(1, 0, 0, 1, 1, 3, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 3, 0, 0, 0, 0);
    add(1, 0, 7, 1, 3, 0, 7, 0, 0, 0);
    for (int i = 0; i < 9; i++) add(1, 0, 7, 1, 3, 0, 7, 0, 0, 0);
    add(1, 1, 7, 1, 3, 0, 7, 0, 0, 0);
    add(1, 0, 15, 1, 3, 0, 7, 0, 0, 0);
    add(1, 1, 15, 1, 3, 0, 7, 0, 0, 0);
    add(1, 0, 10, 1, 3, 0, 7, 0, 0, 0);
    add(1, 1, 0, 1, 3, 0, 7, 0, 0, 0);
    add(0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    add(1, 0, 5, 0, 0, 0, 5, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 5, 0, 1, 0);
    add(1, 1, 0, 1, 0, 0, 5, 0, 0, 0);
    add(1, 0, 2, 0, 0, 5, 2, 0, 1, 0);
    add(1, 1, 0, 1, 0, 5, 2, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      clear_ = vecs[i].clr_n; load_ = vecs[i].ld; bcd_in = vecs[i].bcd; enable_ = vecs[i].en;
      step();
      check($sformatf("vec%0d", i), vecs[i].m, vecs[i].t, vecs[i].o,
            vecs[i].z, vecs[i].r, vecs[i].d);
    end
    clear_ = 1'b1; load_ = 1'b1; enable_ = 1'b1;

    // Countdown with borrows, then asynchronous clear mid-count.
    do_clear();
    load3(1, 0, 0);
    check("load100", 1, 0, 0, 0, 0, 0);
    enable_ = 1'b0; step();
    check("start100", 1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin step(); check("run100", 1, 0, 0, 0, 1, 0); end
    step(); check("dec059", 0, 5, 9, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin step(); check("run059", 0, 5, 9, 0, 1, 0); end
    step(); check("dec058", 0, 5, 8, 0, 1, 0);
    step();
    #2 clear_ = 1'b0; #1;
    check("async_clear", 0, 0, 0, 1, 0, 0);
    enable_ = 1'b1; step();
    check("clear_held", 0, 0, 0, 1, 0, 0);
    clear_ = 1'b1;

    // Completion and DONE behaviour.
    load3(0, 0, 2);
    enable_ = 1'b0; step(); check("start002", 0, 0, 2, 0, 1, 0);
    for (int k = 0; k < 3; k++) step();
    step(); check("dec001", 0, 0, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin step(); check("run001", 0, 0, 1, 0, 1, 0); end
    step(); check("done000", 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 3; k++) begin step(); check("done_hold", 0, 0, 0, 1, 0, 1); end
    load_ = 1'b0; bcd_in = 4'd5; step(); check("done_load", 0, 0, 0, 1, 0, 1);
    load_ = 1'b1; step();
    enable_ = 1'b1; step(); check("done_exit", 0, 0, 0, 1, 0, 0);

    // Pause/resume from 0:90 with loads attempted during RUN.
    do_clear();
    load3(0, 9, 0);
    enable_ = 1'b0; step(); check("start090", 0, 9, 0, 0, 1, 0);
    load_ = 1'b0; bcd_in = 4'd3; step(); check("run_load", 0, 9, 0, 0, 1, 0);
    load_ = 1'b1; step(); step(); check("run090", 0, 9, 0, 0, 1, 0);
    step(); check("dec089", 0, 8, 9, 0, 1, 0);
    step(); step();
    enable_ = 1'b1; step(); check("pause089", 0, 8, 9, 0, 0, 0);
    step(); check("paused", 0, 8, 9, 0, 0, 0);
    enable_ = 1'b0; step(); check("resume", 0, 8, 9, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin step(); check("run089", 0, 8, 9, 0, 1, 0); end
    step(); check("dec088", 0, 8, 8, 0, 1, 0);
    enable_ = 1'b1; step();

    // Random stimulus against the reference model.
    do_clear();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) load_ = ~load_;
      bcd_in = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 11) == 0) enable_ = ~enable_;
      step();
      model_clock();
      check_model("random");
      if ($urandom_range(0, 499) == 0) begin
        clear_ = 1'b0; #1;
        model_reset();
        check_model("random_clear");
        clear_ = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
